// File: rtl/bbm_deadtime_gen.sv
// Break-before-make dead-time generator: one PWM level in, non-overlapping
// high/low gate enables out. Optional minimum on-time hold: BBM_MIN_ON_EN.
module bbm_deadtime_gen #(
  parameter int DT_W     = 6,
  parameter int SENSE_TO = 16,
  parameter int MIN_ON   = 4
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_hs,
  input  logic [DT_W-1:0] dt_ls,
  input  logic            hs_sense,
  input  logic            ls_sense,
  output logic            hs_on,
  output logic            ls_on,
  output logic            fault,
  output logic            busy
);

  localparam int ST_W = $clog2(SENSE_TO + 1);

  typedef enum logic [2:0] {
    S_OFF, S_DT_HS, S_HS_ON, S_DT_LS, S_LS_ON, S_FAULT
  } state_t;

  state_t          state, state_n;
  logic [DT_W-1:0] cnt, cnt_n;
  logic [ST_W-1:0] stm, stm_n;
  logic            hold_busy;

  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  // Counter holds remaining dead cycles minus one, so the turn-on decision
  // lands exactly N edges after entry when it reads zero.
  function automatic logic [DT_W-1:0] load_val(input logic [DT_W-1:0] dt);
    return (dt == '0) ? '0 : dt - DT_W'(1);
  endfunction

`ifdef BBM_MIN_ON_EN
  localparam int MO_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  logic [MO_W-1:0] hold;

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      hold <= '0;
    end else if ((state_n == S_HS_ON || state_n == S_LS_ON) && state_n != state) begin
      hold <= MO_W'(MIN_ON - 1);
    end else if (hold != '0) begin
      hold <= hold - MO_W'(1);
    end
  end

  assign hold_busy = (hold != '0);
`else
  localparam int unused_min_on = MIN_ON;
  assign hold_busy = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stm_n   = stm;
    case (state)
      S_OFF: begin
        stm_n = '0;
        if (pwm_in) begin
          state_n = S_DT_HS;
          cnt_n   = load_val(dt_hs);
        end else begin
          state_n = S_DT_LS;
          cnt_n   = load_val(dt_ls);
        end
      end
      S_DT_HS: begin
        if (!pwm_in) begin
          state_n = S_DT_LS;
          cnt_n   = load_val(dt_ls);
          stm_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - DT_W'(1);
        end else if (!ls_sense) begin
          state_n = S_HS_ON;
        end else if (stm == ST_W'(SENSE_TO)) begin
          state_n = S_FAULT;
        end else begin
          stm_n = stm + ST_W'(1);
        end
      end
      S_DT_LS: begin
        if (pwm_in) begin
          state_n = S_DT_HS;
          cnt_n   = load_val(dt_hs);
          stm_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - DT_W'(1);
        end else if (!hs_sense) begin
          state_n = S_LS_ON;
        end else if (stm == ST_W'(SENSE_TO)) begin
          state_n = S_FAULT;
        end else begin
          stm_n = stm + ST_W'(1);
        end
      end
      S_HS_ON: begin
        if (!hold_busy && !pwm_in) begin
          state_n = S_DT_LS;
          cnt_n   = load_val(dt_ls);
          stm_n   = '0;
        end
      end
      S_LS_ON: begin
        if (!hold_busy && pwm_in) begin
          state_n = S_DT_HS;
          cnt_n   = load_val(dt_hs);
          stm_n   = '0;
        end
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_OFF;
    endcase
    // Disable wins over everything, including the hold and a latched fault.
    if (!en) state_n = S_OFF;
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state <= S_OFF;
      cnt   <= '0;
      stm   <= '0;
      hs_on <= 1'b0;
      ls_on <= 1'b0;
      fault <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      stm   <= stm_n;
      hs_on <= (state_n == S_HS_ON);
      ls_on <= (state_n == S_LS_ON);
      fault <= (state_n == S_FAULT);
      busy  <= (state_n == S_DT_HS) || (state_n == S_DT_LS);
    end
  end

endmodule

// File: tb/tb_bbm_deadtime_gen.sv
// Bench for bbm_deadtime_gen: directed test-plan sequences followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_bbm_deadtime_gen;

  localparam int DT_W     = 6;
  localparam int SENSE_TO = 16;
  localparam int MIN_ON   = 4;
`ifdef BBM_MIN_ON_EN
  localparam int HOLD = MIN_ON;
`else
  localparam int HOLD = 1;
`endif

  logic            clk, rst, en, pwm_in, hs_sense, ls_sense;
  logic [DT_W-1:0] dt_hs, dt_ls;
  logic            hs_on, ls_on, fault, busy;

  int checks = 0;
  int errors = 0;

  bbm_deadtime_gen #(.DT_W(DT_W), .SENSE_TO(SENSE_TO), .MIN_ON(MIN_ON)) dut (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .pwm_in(pwm_in), .dt_hs(dt_hs), .dt_ls(dt_ls),
    .hs_sense(hs_sense), .ls_sense(ls_sense),
    .hs_on(hs_on), .ls_on(ls_on), .fault(fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 off, 1 dead, 2 on, 3 fault; side 1 = high side.
  int m_phase = 0, m_side = 0, m_left = 0, m_wait = 0, m_age = 0;
  logic e_hs = 0, e_ls = 0, e_fault = 0, e_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic enter_dead(input int side);
    int dt;
    dt = side ? int'(dt_hs) : int'(dt_ls);
    m_phase = 1;
    m_side  = side;
    m_left  = (dt == 0) ? 1 : dt;
    m_wait  = 0;
  endtask

  task automatic model_step();
    int opp;
    if (rst || !en) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: enter_dead(int'(pwm_in));
        1: begin
          if (int'(pwm_in) != m_side) enter_dead(int'(pwm_in));
          else if (m_left > 1) m_left--;
          else begin
            opp = m_side ? int'(ls_sense) : int'(hs_sense);
            if (opp == 0) begin
              m_phase = 2;
              m_age   = 1;
            end else begin
              m_wait++;
              if (m_wait > SENSE_TO) m_phase = 3;
            end
          end
        end
        2: begin
          if (m_age < HOLD) m_age++;
          else if (int'(pwm_in) != m_side) enter_dead(int'(pwm_in));
        end
        default: ;
      endcase
    end
    e_hs    = (m_phase == 2) && (m_side == 1);
    e_ls    = (m_phase == 2) && (m_side == 0);
    e_fault = (m_phase == 3);
    e_busy  = (m_phase == 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("hs_on", hs_on, e_hs);
    check("ls_on", ls_on, e_ls);
    check("fault", fault, e_fault);
    check("busy", busy, e_busy);
    check("overlap", hs_on & ls_on, 0);
  endtask

  int stuck_h = 0, stuck_l = 0;

  initial begin
    rst = 1; en = 0; pwm_in = 0; dt_hs = 0; dt_ls = 0; hs_sense = 0; ls_sense = 0;
    @(negedge clk);
    tick(); tick();
    check("rst_hs", hs_on, 0);
    check("rst_ls", ls_on, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    rst = 0;

    // Low-side start with 3-cycle dead time
    en = 1; pwm_in = 0; dt_ls = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_busy", busy, 1);
      check("t1_hs", hs_on, 0);
    end
    tick();
    check("t1_ls_on", ls_on, 1);

    // Low to high with dt_hs=5
    dt_hs = 5; pwm_in = 1;
    tick();
    check("t2_ls_off", ls_on, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hs_wait", hs_on, 0);
    end
    tick();
    check("t2_hs_on", hs_on, 1);

    // dt=0 gives a single dead cycle
    dt_ls = 0; pwm_in = 0;
    tick();
    check("t3_dead", busy, 1);
    tick();
    check("t3_ls_on", ls_on, 1);

    // Abort a high-side dead time back to the low side
    dt_hs = 6; dt_ls = 3; pwm_in = 1;
    tick(); tick();
    pwm_in = 0;
    tick();
    check("t4_busy", busy, 1);
    tick(); tick();
    check("t4_hs", hs_on, 0);
    tick();
    check("t4_ls_on", ls_on, 1);

    // Sense fault: low side never reports off
    dt_hs = 2; ls_sense = 1; pwm_in = 1;
    for (int i = 0; i < 18; i++) tick();
    check("t5_pre", fault, 0);
    tick();
    check("t5_fault", fault, 1);
    check("t5_hs", hs_on, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_sticky", fault, 1);
    end
    en = 0;
    tick();
    check("t5_clear", fault, 0);
    en = 1; ls_sense = 0;
    tick(); tick(); tick();
    check("t6_hs_on", hs_on, 1);

    // One-cycle low glitch right after high-side entry
    pwm_in = 0;
    tick();
    pwm_in = 1;
`ifdef BBM_MIN_ON_EN
    check("t6_glitch_hold", hs_on, 1);
`else
    check("t6_glitch_dt", busy, 1);
`endif
    for (int i = 0; i < 10; i++) tick();

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 11) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 7) == 0) dt_hs = DT_W'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) dt_ls = DT_W'($urandom_range(0, 9));
      if (stuck_h == 0 && $urandom_range(0, 49) == 0) stuck_h = $urandom_range(1, 24);
      if (stuck_l == 0 && $urandom_range(0, 49) == 0) stuck_l = $urandom_range(1, 24);
      hs_sense = (stuck_h > 0) ? 1'b1 : e_hs;
      ls_sense = (stuck_l > 0) ? 1'b1 : e_ls;
      if (stuck_h > 0) stuck_h--;
      if (stuck_l > 0) stuck_l--;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
